// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch: prescaled tick, IDLE/RUN/PAUSE control, sticky wrap flag.
// Optional lap freeze of the displayed value is built when LAP_STOPWATCH_EN is defined.
module bcd_stopwatch #(
  parameter int unsigned TICK_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] count,
  output logic        running,
  output logic        overflow
);

  localparam int unsigned PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] TickMax = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   digits_q, digits_d;
  logic          ovf_q, ovf_d;
  logic          running_q;
  logic          tick;

  function automatic logic [15:0] bcd_inc(input logic [15:0] d);
    logic [15:0] r;
    logic        c;
    r = d;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (d[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    tick     = 1'b0;
    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        if (start_stop) state_d = StRun;
      end
      StRun: begin
        if (presc_q == TickMax) begin
          tick    = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (start_stop) state_d = StPause;
      end
      StPause: begin
        if (start_stop) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
    if (tick) begin
      digits_d = bcd_inc(digits_q);
      if (digits_q == 16'h9999) ovf_d = 1'b1;
    end
    if (clear) begin
      state_d  = StIdle;
      presc_d  = '0;
      digits_d = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      running_q <= (state_d == StRun);
    end
  end

  assign running  = running_q;
  assign overflow = ovf_q;

`ifdef LAP_STOPWATCH_EN
  logic        lap_active_q, lap_active_d;
  logic [15:0] lap_reg_q, lap_reg_d;

  always_comb begin
    lap_active_d = lap_active_q;
    lap_reg_d    = lap_reg_q;
    if (clear) begin
      lap_active_d = 1'b0;
    end else if (lap) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else if (state_q == StRun) begin
        lap_active_d = 1'b1;
        lap_reg_d    = digits_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_active_q <= 1'b0;
      lap_reg_q    <= '0;
    end else begin
      lap_active_q <= lap_active_d;
      lap_reg_q    <= lap_reg_d;
    end
  end

  assign count = lap_active_q ? lap_reg_q : digits_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign count      = digits_q;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch with TICK_CYCLES=4; inputs driven and outputs sampled at negedge.
module tb_bcd_stopwatch;

  logic        clk;
  logic        rst;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [15:0] count;
  logic        running;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_stopwatch #(
    .TICK_CYCLES(4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .count     (count),
    .running   (running),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  int bad_nibbles = 0;

  // Advance until count reaches target, recording any non-BCD digit seen on the way.
  task automatic wait_count(input logic [15:0] target, input int bound, output logic found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (count[4*k +: 4] > 4'd9) bad_nibbles++;
      if (count == target) found = 1'b1;
    end
  endtask

  logic found;

  initial begin
    rst        = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    cyc(2);
    rst = 1'b0;
    check("rst_count", count, 16'h0000);
    check("rst_running", 16'(running), 16'h0001 ^ 16'h0001);
    check("rst_overflow", 16'(overflow), 16'h0000);
    cyc(20);
    check("idle_hold_count", count, 16'h0000);
    check("idle_running", 16'(running), 16'h0000);

    // Count from zero: one increment every 4 cycles
    pulse_ss();
    check("run_running", 16'(running), 16'h0001);
    check("run_count0", count, 16'h0000);
    cyc(3);
    check("pre_first_tick", count, 16'h0000);
    cyc(1);
    check("first_tick", count, 16'h0001);
    cyc(35);
    check("count_0009", count, 16'h0009);
    cyc(1);
    check("count_0010", count, 16'h0010);

    // Pause with prescaler at 2, then resume
    cyc(1);
    pulse_ss();
    check("pause_running", 16'(running), 16'h0000);
    cyc(10);
    check("pause_frozen", count, 16'h0010);
    pulse_ss();
    check("resume_running", 16'(running), 16'h0001);
    check("resume_no_inc", count, 16'h0010);
    cyc(1);
    check("resume_1clk", count, 16'h0010);
    cyc(1);
    check("resume_2clk", count, 16'h0011);

    // Clear together with start_stop while running
    start_stop = 1'b1;
    clear      = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    clear      = 1'b0;
    check("clr_ss_count", count, 16'h0000);
    check("clr_ss_running", 16'(running), 16'h0000);
    cyc(8);
    check("clr_ss_idle", count, 16'h0000);

    // Lap freeze (or no effect in the default build)
    pulse_ss();
    cyc(20);
    check("lap_pre", count, 16'h0005);
    pulse_lap();
    check("lap_taken", count, 16'h0005);
    cyc(12);
`ifdef LAP_STOPWATCH_EN
    check("lap_frozen", count, 16'h0005);
`else
    check("lap_ignored", count, 16'h0008);
`endif
    cyc(19);
    pulse_lap();
    check("lap_release", count, 16'h0013);
    pulse_clear();
    check("lap_clear", count, 16'h0000);

    // Carry into thousands and 9999 wrap
    pulse_ss();
    wait_count(16'h0999, 5000, found);
    check("wait_0999", 16'(found), 16'h0001);
    cyc(3);
    check("hold_0999", count, 16'h0999);
    cyc(1);
    check("carry_1000", count, 16'h1000);
    wait_count(16'h9999, 40000, found);
    check("wait_9999", 16'(found), 16'h0001);
    check("pre_wrap_ovf", 16'(overflow), 16'h0000);
    cyc(4);
    check("wrap_count", count, 16'h0000);
    check("wrap_ovf", 16'(overflow), 16'h0001);
    cyc(8);
    check("post_wrap_count", count, 16'h0002);
    check("ovf_sticky", 16'(overflow), 16'h0001);
    check("bcd_digits", 16'(bad_nibbles), 16'h0000);
    pulse_clear();
    check("clr_ovf", 16'(overflow), 16'h0000);
    check("clr_count", count, 16'h0000);
    check("clr_running", 16'(running), 16'h0000);

    // Synchronous reset while running
    pulse_ss();
    cyc(9);
    check("rerun_count", count, 16'h0002);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run_count", count, 16'h0000);
    check("rst_run_running", 16'(running), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
